// File: rtl/iddmm_issue.sv
// ---------------------------------------------------------------------------
// iddmm_issue
// Operand sequencer for the iddmm_cal word pipeline. For each outer iteration
// i it reads the x/y/p/a word RAMs and issues one gap-free burst of N+1
// words (j_cnt = 0..N). It then waits for the pipeline's N write-backs of a
// before the next iteration starts, so that a is never read before it is
// written.
//
// Ports
//   clk, rst              clock, asynchronous active-high reset
//   start                 one-cycle pulse, accepted only while idle
//   busy, done, err       status: busy during a run, done pulse at the end,
//                         sticky error on an out-of-order write-back
//   x/y/p/a_rd_addr       RAM read addresses (1-cycle synchronous RAMs)
//   x/y/p/a_rd_data       RAM read data
//   j_cnt, x, y, p, a     operand stream to iddmm_cal
//   wr_a_en, wr_a_addr    snooped a-RAM write-back from iddmm_cal
// ---------------------------------------------------------------------------
module iddmm_issue #(
  parameter int K      = 128,
  parameter int N      = 32,
  parameter int ADDR_W = $clog2(N)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] x_rd_addr,
  input  logic [K-1:0]      x_rd_data,
  output logic [ADDR_W-1:0] y_rd_addr,
  input  logic [K-1:0]      y_rd_data,
  output logic [ADDR_W-1:0] p_rd_addr,
  input  logic [K-1:0]      p_rd_data,
  output logic [ADDR_W-1:0] a_rd_addr,
  input  logic [K-1:0]      a_rd_data,
  output logic [ADDR_W:0]   j_cnt,
  output logic [K-1:0]      x,
  output logic [K-1:0]      y,
  output logic [K-1:0]      p,
  output logic [K-1:0]      a,
  input  logic              wr_a_en,
  input  logic [ADDR_W-1:0] wr_a_addr
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREFETCH,
    S_ISSUE,
    S_WAIT,
    S_DONE
  } state_t;

  localparam logic [ADDR_W:0]   J_LAST  = (ADDR_W+1)'(N);
  localparam logic [ADDR_W:0]   WB_LAST = (ADDR_W+1)'(N-1);
  localparam logic [ADDR_W-1:0] I_LAST  = ADDR_W'(N-1);

  state_t            state;
  logic [ADDR_W-1:0] i;
  logic [ADDR_W:0]   wb;
  logic [ADDR_W-1:0] rd_addr;
  logic              wb_hit;
  logic              wb_full;
  logic              issuing;
  logic              last_word;

  // Write-backs are only meaningful while a burst is in flight.
  assign wb_hit  = wr_a_en && (state == S_ISSUE || state == S_WAIT);
  // Leave WAIT on the same edge that counts the N-th write-back, so the
  // next burst starts two cycles after the last wr_a_en.
  assign wb_full = (wb == J_LAST) || (wb_hit && wb == WB_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      i       <= '0;
      wb      <= '0;
      rd_addr <= '0;
      j_cnt   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (wb_hit) begin
        wb <= wb + (ADDR_W+1)'(1);
        if ({1'b0, wr_a_addr} != wb) err <= 1'b1;
      end
      case (state)
        S_IDLE: begin
          if (start) begin
            state   <= S_PREFETCH;
            busy    <= 1'b1;
            err     <= 1'b0;
            i       <= '0;
            wb      <= '0;
            rd_addr <= '0;
          end
        end
        S_PREFETCH: begin
          // Word 0 is being read now; the next address goes out with j_cnt=0.
          state   <= S_ISSUE;
          j_cnt   <= '0;
          rd_addr <= ADDR_W'(1);
        end
        S_ISSUE: begin
          if (j_cnt == J_LAST) begin
            state <= S_WAIT;
            j_cnt <= '0;
          end else begin
            j_cnt <= j_cnt + (ADDR_W+1)'(1);
          end
          rd_addr <= rd_addr + ADDR_W'(1);
        end
        S_WAIT: begin
          if (wb_full) begin
            wb      <= '0;
            rd_addr <= '0;
            if (i == I_LAST) begin
              state <= S_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
              i     <= '0;
            end else begin
              state <= S_PREFETCH;
              i     <= i + ADDR_W'(1);
            end
          end
        end
        S_DONE: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign issuing   = (state == S_ISSUE);
  assign last_word = (j_cnt == J_LAST);

  assign x_rd_addr = i;
  assign y_rd_addr = rd_addr;
  assign p_rd_addr = rd_addr;
  assign a_rd_addr = rd_addr;

  // The extra word at j_cnt=N flushes the pipeline with zero operands; a is
  // forced to zero on the first iteration so the a RAM needs no pre-clear.
  assign x = issuing ? x_rd_data : '0;
  assign y = (issuing && !last_word) ? y_rd_data : '0;
  assign p = (issuing && !last_word) ? p_rd_data : '0;
  assign a = (issuing && !last_word && i != '0) ? a_rd_data : '0;

endmodule

// File: tb/tb_iddmm_issue.sv
module tb_iddmm_issue;
  localparam int K  = 128;
  localparam int N  = 4;
  localparam int AW = 2;
  localparam int D  = 28;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          busy, done, err;
  logic [AW-1:0] x_rd_addr, y_rd_addr, p_rd_addr, a_rd_addr;
  logic [K-1:0]  x_rd_data, y_rd_data, p_rd_data, a_rd_data;
  logic [AW:0]   j_cnt;
  logic [K-1:0]  x, y, p, a;
  logic          wr_a_en = 1'b0;
  logic [AW-1:0] wr_a_addr = '0;

  iddmm_issue #(.K(K), .N(N), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .err(err),
    .x_rd_addr(x_rd_addr), .x_rd_data(x_rd_data),
    .y_rd_addr(y_rd_addr), .y_rd_data(y_rd_data),
    .p_rd_addr(p_rd_addr), .p_rd_data(p_rd_data),
    .a_rd_addr(a_rd_addr), .a_rd_data(a_rd_data),
    .j_cnt(j_cnt), .x(x), .y(y), .p(p), .a(a),
    .wr_a_en(wr_a_en), .wr_a_addr(wr_a_addr)
  );

  always #5 clk = ~clk;

  logic [K-1:0] x_ram [N];
  logic [K-1:0] y_ram [N];
  logic [K-1:0] p_ram [N];
  logic [K-1:0] a_ram [N];

  always @(posedge clk) begin
    x_rd_data <= x_ram[x_rd_addr];
    y_rd_data <= y_ram[y_rd_addr];
    p_rd_data <= p_ram[p_rd_addr];
    a_rd_data <= a_ram[a_rd_addr];
  end

  int n_chk = 0;
  int n_fail = 0;
  int t = 0;

  // Reference schedule of the current run, in bench cycles.
  bit run_active = 0;
  int busy_from, bs, done_cyc, m_i, wc;
  bit err_exp = 0;
  bit start_req = 0, perm_mode = 0, spurious = 0;
  int jq[$];

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, t);
    end
  endtask

  function automatic logic [K-1:0] rnd_word();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic cycle();
    int j, d, addr;
    @(negedge clk);
    if (run_active && t > done_cyc) run_active = 0;
    check_eq("busy", busy, run_active && t >= busy_from && t < done_cyc);
    check_eq("done", done, run_active && t == done_cyc);
    check_eq("err", err, err_exp);
    if (run_active && t >= bs && t <= bs + N) begin
      j = t - bs;
      check_eq("j_cnt", j_cnt, j);
      check_eq("x", x, x_ram[m_i]);
      check_eq("y", y, (j < N) ? y_ram[j] : '0);
      check_eq("p", p, (j < N) ? p_ram[j] : '0);
      check_eq("a", a, (m_i > 0 && j < N) ? a_ram[j] : '0);
      if (j + 1 < N) begin
        check_eq("y_rd_addr", y_rd_addr, j + 1);
        check_eq("a_rd_addr", a_rd_addr, j + 1);
      end
    end else begin
      check_eq("j_cnt_idle", j_cnt, 0);
      check_eq("data_idle", x | y | p | a, 0);
      if (run_active && t == bs - 1) begin
        check_eq("pf_x_addr", x_rd_addr, m_i);
        check_eq("pf_y_addr", y_rd_addr, 0);
      end
    end

    // iddmm_cal stand-in: j_cnt delayed by D cycles, word j-1 written back for j=1..N.
    jq.push_back(int'(j_cnt));
    wr_a_en = 1'b0;
    wr_a_addr = '0;
    if (jq.size() > D) begin
      d = jq.pop_front();
      if (d >= 1 && d <= N) begin
        addr = d - 1;
        if (perm_mode && m_i == 0) addr = (addr == 1) ? 2 : (addr == 2) ? 1 : addr;
        a_ram[addr] = rnd_word();
        wr_a_en = 1'b1;
        wr_a_addr = AW'(addr);
        if (run_active) begin
          if (addr != wc) err_exp = 1;
          wc++;
          if (wc == N) begin
            if (m_i == N - 1) done_cyc = t + 1;
            else begin
              m_i++;
              bs = t + 2;
              wc = 0;
            end
          end
        end
      end
    end
    if (!wr_a_en && spurious && !run_active && $urandom_range(0, 2) == 0) begin
      wr_a_en = 1'b1;
      wr_a_addr = AW'($urandom_range(0, N - 1));
    end

    start = 1'b0;
    if (start_req) begin
      start = 1'b1;
      start_req = 0;
      if (!run_active) begin
        run_active = 1;
        busy_from = t + 1;
        bs = t + 2;
        m_i = 0;
        wc = 0;
        err_exp = 0;
        done_cyc = 1 << 30;
      end
    end
    t++;
  endtask

  task automatic run_until_idle(input int budget);
    int k;
    k = 0;
    while (run_active && k < budget) begin
      if (k == 20) start_req = 1;          // ignored: run in progress
      if (t == done_cyc) start_req = 1;    // ignored: DONE state
      cycle();
      k++;
    end
    if (run_active) begin
      check_eq("run_timeout", 1, 0);
      run_active = 0;
    end
  endtask

  task automatic begin_run();
    start_req = 1;
    cycle();
  endtask

  task automatic reset_mid_issue();
    int k;
    k = 0;
    while (t != bs + 2 && k < 50) begin
      cycle();
      k++;
    end
    if (t != bs + 2) check_eq("rst_wait_timeout", 1, 0);
    @(negedge clk);
    check_eq("j_cnt_pre_rst", j_cnt, 2);
    rst = 1'b1;
    #1;
    check_eq("rst_j_cnt", j_cnt, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_err", err, 0);
    check_eq("rst_data", x | y | p | a, 0);
    check_eq("rst_addr", {x_rd_addr, y_rd_addr, p_rd_addr, a_rd_addr}, 0);
    jq.delete();
    run_active = 0;
    err_exp = 0;
    wr_a_en = 1'b0;
    start = 1'b0;
    t++;
    @(negedge clk);
    rst = 1'b0;
    t++;
  endtask

  initial begin
    for (int n = 0; n < N; n++) begin
      x_ram[n] = K'(32'hA0 + n);
      y_ram[n] = K'(n + 1);
      p_ram[n] = K'(32'h10 + n);
      a_ram[n] = {16{8'h55}};
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;

    repeat (10) cycle();
    begin_run();
    run_until_idle(400);
    repeat (3) cycle();

    for (int n = 0; n < N; n++) begin
      x_ram[n] = rnd_word();
      y_ram[n] = rnd_word();
      p_ram[n] = rnd_word();
    end
    spurious = 1;
    repeat (12) cycle();
    spurious = 0;
    begin_run();
    run_until_idle(400);

    perm_mode = 1;
    begin_run();
    run_until_idle(400);
    perm_mode = 0;
    repeat (2) cycle();
    begin_run();
    run_until_idle(400);

    begin_run();
    reset_mid_issue();
    repeat (5) cycle();
    for (int n = 0; n < N; n++) y_ram[n] = rnd_word();
    begin_run();
    run_until_idle(400);
    repeat (3) cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
